pair_wise_divider: RTL and testbench

- Sequential restoring divider; the inverse of the pipelined pair-wise multiplier.
- Takes a 2N-bit product-width dividend and an N-bit divisor.
- Returns a 2N-bit quotient and an N-bit remainder, one quotient bit per clock.
- Sits downstream of the multiplier datapath to recover operands and check products; valid/ready handshake on both sides.

---
 rtl/pair_wise_divider.sv | 131 +++++++++++++
 tb/tb_pair_wise_divider.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/pair_wise_divider.sv
// Sequential restoring divider: 2N-bit dividend by N-bit divisor, one quotient
// bit per clock, valid/ready handshake on both sides.
module pair_wise_divider #(
  parameter int N = 4
) (
  input  logic           clk1,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [2*N-1:0] dividend,
  input  logic [N-1:0]   divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] quotient,
  output logic [N-1:0]   remainder,
  output logic           div_zero
);

  localparam int CNT_W = $clog2(2*N+1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r, state_s;
  logic [2*N-1:0]   qreg_r, qreg_s;
  logic [N:0]       prem_r, prem_s;
  logic [N-1:0]     dvsr_r, dvsr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [2*N-1:0]   quot_s;
  logic [N-1:0]     rem_s;
  logic             dz_s;
  logic [N:0]       shifted_s, trial_s;
  logic [2*N-1:0]   qshift_s;

  // Next-state, datapath step and result capture
  always_comb begin
    state_s   = state_r;
    qreg_s    = qreg_r;
    prem_s    = prem_r;
    dvsr_s    = dvsr_r;
    cnt_s     = cnt_r;
    quot_s    = quotient;
    rem_s     = remainder;
    dz_s      = div_zero;
    // Partial remainder is N+1 bits so the shift cannot overflow before the subtract
    shifted_s = {prem_r[N-1:0], qreg_r[2*N-1]};
    trial_s   = shifted_s - {1'b0, dvsr_r};
    qshift_s  = {qreg_r[2*N-2:0], ~trial_s[N]};
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          qreg_s = dividend;
          dvsr_s = divisor;
          prem_s = '0;
          cnt_s  = CNT_W'(2*N);
          if (divisor != '0) begin
            state_s = CALC;
          end else begin
            state_s = DONE;
            quot_s  = '1;
            rem_s   = dividend[N-1:0];
            dz_s    = 1'b1;
          end
        end else begin
          state_s = IDLE;
        end
      end
      CALC: begin
        qreg_s = qshift_s;
        prem_s = trial_s[N] ? shifted_s : trial_s;
        cnt_s  = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          state_s = DONE;
          quot_s  = qshift_s;
          rem_s   = prem_s[N-1:0];
          dz_s    = 1'b0;
        end else begin
          state_s = CALC;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State and working registers
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
      qreg_r  <= '0;
      prem_r  <= '0;
      dvsr_r  <= '0;
      cnt_r   <= '0;
    end else begin
      state_r <= state_s;
      qreg_r  <= qreg_s;
      prem_r  <= prem_s;
      dvsr_r  <= dvsr_s;
      cnt_r   <= cnt_s;
    end
  end

  // Registered handshake and result outputs
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      in_ready  <= (state_s == IDLE);
      out_valid <= (state_s == DONE);
      quotient  <= quot_s;
      remainder <= rem_s;
      div_zero  <= dz_s;
    end
  end

endmodule

// File: tb/tb_pair_wise_divider.sv
// Directed bench for pair_wise_divider: latency, results, backpressure,
// divide-by-zero, mid-operation reset and an exhaustive operand sweep.
module tb_pair_wise_divider;

  localparam int N = 4;

  logic           clk1 = 1'b0;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [2*N-1:0] dividend;
  logic [N-1:0]   divisor;
  logic           out_valid;
  logic           out_ready;
  logic [2*N-1:0] quotient;
  logic [N-1:0]   remainder;
  logic           div_zero;

  int checks = 0;
  int errors = 0;

  always #5 clk1 = ~clk1;

  pair_wise_divider #(.N(N)) dut (
    .clk1      (clk1),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .dividend  (dividend),
    .divisor   (divisor),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one operation, check latency and result, optionally hold the result, then hand off.
  task automatic op(input logic [7:0] a, input logic [3:0] b, input logic [7:0] eq,
                    input logic [3:0] er, input logic edz, input int elat, input int hold);
    int w;
    int lat;
    w = 0;
    lat = 0;
    @(negedge clk1);
    while (in_ready !== 1'b1 && w < 20) begin
      @(negedge clk1);
      w++;
    end
    check("in_ready_idle", in_ready, 1);
    in_valid = 1'b1;
    dividend = a;
    divisor  = b;
    @(negedge clk1);
    in_valid = 1'b0;
    dividend = 8'($urandom);
    divisor  = 4'($urandom);
    check("in_ready_busy", in_ready, 0);
    while (out_valid !== 1'b1 && lat < 20) begin
      @(negedge clk1);
      lat++;
      if (out_valid !== 1'b1) check("in_ready_calc", in_ready, 0);
    end
    check("latency", lat, elat);
    check("quotient", quotient, eq);
    check("remainder", remainder, er);
    check("div_zero", div_zero, edz);
    for (int i = 0; i < hold; i++) begin
      in_valid = (i == 1);
      dividend = 8'd99;
      divisor  = 4'd3;
      @(negedge clk1);
      check("hold_valid", out_valid, 1);
      check("hold_in_ready", in_ready, 0);
      check("hold_quotient", quotient, eq);
      check("hold_remainder", remainder, er);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk1);
    out_ready = 1'b0;
    check("handoff_valid", out_valid, 0);
    check("handoff_in_ready", in_ready, 1);
  endtask

  initial begin
    #1500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    dividend  = 8'd0;
    divisor   = 4'd0;
    #12;
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_quotient", quotient, 0);
    check("rst_remainder", remainder, 0);
    check("rst_div_zero", div_zero, 0);
    @(negedge clk1);
    rst_n = 1'b1;

    op(8'd130, 4'd13, 8'd10, 4'd0, 1'b0, 8, 0);
    op(8'd165, 4'd11, 8'd15, 4'd0, 1'b0, 8, 0);
    op(8'd100, 4'd10, 8'd10, 4'd0, 1'b0, 8, 0);
    op(8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 8, 0);
    op(8'd255, 4'd1, 8'd255, 4'd0, 1'b0, 8, 0);
    op(8'd255, 4'd15, 8'd17, 4'd0, 1'b0, 8, 0);
    op(8'd42, 4'd0, 8'hFF, 4'hA, 1'b1, 0, 0);
    op(8'd50, 4'd5, 8'd10, 4'd0, 1'b0, 8, 0);
    op(8'd77, 4'd6, 8'd12, 4'd5, 1'b0, 8, 5);
    // The pulse issued during the hold must not have started an operation
    @(negedge clk1);
    check("no_queued_op", out_valid, 0);

    // Reset asserted in the middle of a calculation
    in_valid = 1'b1;
    dividend = 8'd200;
    divisor  = 4'd7;
    @(negedge clk1);
    in_valid = 1'b0;
    repeat (3) @(negedge clk1);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_quotient", quotient, 0);
    check("midrst_remainder", remainder, 0);
    check("midrst_div_zero", div_zero, 0);
    @(negedge clk1);
    rst_n = 1'b1;
    op(8'd143, 4'd11, 8'd13, 4'd0, 1'b0, 8, 0);

    for (int a = 0; a < 256; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) begin
          op(8'(a), 4'(b), 8'hFF, 4'(a % 16), 1'b1, 0, 0);
        end else begin
          op(8'(a), 4'(b), 8'(a / b), 4'(a % b), 1'b0, 8, 0);
          check("sweep_invariant", int'(quotient) * b + int'(remainder), a);
          check("sweep_rem_lt_div", (int'(remainder) < b), 1);
        end
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
